bus_regfile: RTL and testbench

BUS_REGFILE -- requirements
Module: bus_regfile

---
 rtl/bus_regfile_if.sv | 31 +++
 rtl/bus_regfile.sv | 153 +++++++++++++++
 tb/tb_bus_regfile.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_regfile_if.sv
// Core/host bus bundle for bus_regfile: request/response handshake, writeback and host write port.
interface bus_regfile_if;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;

  logic [3:0]    busreq;
  logic [AW-1:0] opnd;
  logic          done;
  logic [DW-1:0] result;
  logic          carry;
  logic [AW-1:0] wb_dest;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [AW-1:0] next_opnd;
  logic          opnd_valid;
  logic          carry_flag;
  logic          bad_req;

  modport master (
    output busreq, opnd, done, result, carry, wb_dest, host_we, host_addr, host_wdata,
    input  data_out, data_valid, next_opnd, opnd_valid, carry_flag, bad_req
  );

  modport slave (
    input  busreq, opnd, done, result, carry, wb_dest, host_we, host_addr, host_wdata,
    output data_out, data_valid, next_opnd, opnd_valid, carry_flag, bad_req
  );
endinterface

// File: rtl/bus_regfile.sv
// 16x4 register file serving core read/operand handshakes, host writes and optional writeback.
// Macro BUS_REGFILE_WB_EN enables the done-triggered writeback path (WB state, carry_flag).
module bus_regfile #(
  parameter logic [3:0] RESET_OPND = 4'd3
) (
  input logic          clk,
  input logic          rst,
  bus_regfile_if.slave bus
);
  localparam int unsigned DW   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 16;

  localparam logic [3:0] REQ_IDLE = 4'b0000;
  localparam logic [3:0] REQ_READ = 4'b0001;
  localparam logic [3:0] REQ_OPND = 4'b0011;

`ifdef BUS_REGFILE_WB_EN
  typedef enum logic [1:0] {IDLE, READ, OPND, WB} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, OPND} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    busreq_q;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic [AW-1:0] next_opnd_q, next_opnd_d;
  logic          opnd_valid_q, opnd_valid_d;
  logic          carry_flag_q, carry_flag_d;
  logic          bad_req_q, bad_req_d;

`ifdef BUS_REGFILE_WB_EN
  logic done_q;
  logic wb_fire;
  logic wb_we;

  assign wb_fire = bus.done & ~done_q;
  // Host write wins a same-register collision; the writeback data is dropped.
  assign wb_we   = wb_fire && (bus.wb_dest != '0) &&
                   !(bus.host_we && (bus.host_addr == bus.wb_dest));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= bus.done;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.done, bus.result, bus.carry, bus.wb_dest};
`endif

  // Register storage; R0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (bus.host_we && (bus.host_addr != '0)) regs[bus.host_addr] <= bus.host_wdata;
`ifdef BUS_REGFILE_WB_EN
      if (wb_we) regs[bus.wb_dest] <= bus.result;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= RESET_OPND;
      busreq_q     <= REQ_IDLE;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      next_opnd_q  <= '0;
      opnd_valid_q <= 1'b0;
      carry_flag_q <= 1'b0;
      bad_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busreq_q     <= bus.busreq;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      next_opnd_q  <= next_opnd_d;
      opnd_valid_q <= opnd_valid_d;
      carry_flag_q <= carry_flag_d;
      bad_req_q    <= bad_req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    next_opnd_d  = next_opnd_q;
    opnd_valid_d = opnd_valid_q;
    carry_flag_d = carry_flag_q;
    // Pulse only on the edge an unknown code first appears.
    bad_req_d    = (bus.busreq != busreq_q) && (bus.busreq != REQ_IDLE) &&
                   (bus.busreq != REQ_READ) && (bus.busreq != REQ_OPND);

    case (state_q)
      IDLE: begin
        if (bus.busreq == REQ_READ) begin
          state_d      = READ;
          data_out_d   = regs[bus.opnd];
          data_valid_d = 1'b1;
        end else if (bus.busreq == REQ_OPND) begin
          state_d      = OPND;
          next_opnd_d  = ptr_q;
          opnd_valid_d = 1'b1;
        end
      end
      READ: begin
        if (bus.busreq != REQ_READ) begin
          state_d      = IDLE;
          data_valid_d = 1'b0;
        end
      end
      OPND: begin
        if (bus.busreq != REQ_OPND) begin
          state_d      = IDLE;
          opnd_valid_d = 1'b0;
          ptr_d        = ptr_q + AW'(1);
        end
      end
`ifdef BUS_REGFILE_WB_EN
      WB:      state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

`ifdef BUS_REGFILE_WB_EN
    // A done edge preempts any handshake without advancing the pointer.
    if (wb_fire) begin
      state_d      = WB;
      ptr_d        = ptr_q;
      data_valid_d = 1'b0;
      opnd_valid_d = 1'b0;
      carry_flag_d = bus.carry;
    end
`else
    carry_flag_d = 1'b0;
`endif
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.next_opnd  = next_opnd_q;
  assign bus.opnd_valid = opnd_valid_q;
  assign bus.carry_flag = carry_flag_q;
  assign bus.bad_req    = bad_req_q;
endmodule

// File: tb/tb_bus_regfile.sv
// Directed + randomized bench for bus_regfile against an array/pointer reference model.
module tb_bus_regfile;
`ifdef BUS_REGFILE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;

  int   m_regs [16];
  int   m_ptr;
  int   m_carry;

  bus_regfile_if bus ();

  bus_regfile #(.RESET_OPND(4'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_ptr   = 3;
    m_carry = 0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a != 0) m_regs[a] = d % 16;
  endtask

  task automatic host_write(input int a, input int d);
    bus.host_we    = 1'b1;
    bus.host_addr  = 4'(a);
    bus.host_wdata = 4'(d);
    step();
    bus.host_we    = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_read(input string tag, input int a);
    bus.busreq = 4'b0001;
    bus.opnd   = 4'(a);
    step();
    check({tag, "_valid"}, int'(bus.data_valid), 1);
    check({tag, "_data"}, int'(bus.data_out), m_regs[a]);
    bus.busreq = 4'b0000;
    step();
    check({tag, "_clr"}, int'(bus.data_valid), 0);
  endtask

  task automatic do_opnd(input string tag);
    bus.busreq = 4'b0011;
    step();
    check({tag, "_valid"}, int'(bus.opnd_valid), 1);
    check({tag, "_idx"}, int'(bus.next_opnd), m_ptr % 16);
    bus.busreq = 4'b0000;
    step();
    check({tag, "_clr"}, int'(bus.opnd_valid), 0);
    m_ptr = (m_ptr + 1) % 16;
  endtask

  task automatic writeback(input int dest, input int res, input int cy);
    bus.done    = 1'b1;
    bus.wb_dest = 4'(dest);
    bus.result  = 4'(res);
    bus.carry   = cy[0];
  endtask

  initial begin
    int a, d;
    bus.busreq = '0; bus.opnd = '0; bus.done = 1'b0; bus.result = '0; bus.carry = 1'b0;
    bus.wb_dest = '0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    model_reset();

    #1 rst = 1'b1;
    #2;
    check("rst_data_out", int'(bus.data_out), 0);
    check("rst_data_valid", int'(bus.data_valid), 0);
    check("rst_next_opnd", int'(bus.next_opnd), 0);
    check("rst_opnd_valid", int'(bus.opnd_valid), 0);
    check("rst_carry_flag", int'(bus.carry_flag), 0);
    check("rst_bad_req", int'(bus.bad_req), 0);
    step(); step();
    rst = 1'b0;
    step();

    // Operand pointer: 3,4,5 then 13 more wrapping through 15 -> 0
    for (int i = 0; i < 16; i++) do_opnd($sformatf("opnd%0d", i));

    host_write(1, 4); host_write(2, 5); host_write(3, 6); host_write(4, 3);
    do_read("rd_r3", 3);
    check("rd_r3_const", m_regs[3], 6);

    // Response stays stable while request is held
    bus.busreq = 4'b0001; bus.opnd = 4'd2;
    step();
    bus.opnd = 4'd4;
    step();
    check("hold_valid", int'(bus.data_valid), 1);
    check("hold_data", int'(bus.data_out), m_regs[2]);
    bus.busreq = 4'b0000;
    step();

    // Unrecognised code: one-cycle pulse, no response
    bus.busreq = 4'b0101;
    step();
    check("bad_pulse", int'(bus.bad_req), 1);
    check("bad_no_valid", int'(bus.data_valid), 0);
    step();
    check("bad_one_cycle", int'(bus.bad_req), 0);
    bus.busreq = 4'b0000;
    step();

    host_write(0, 7);
    do_read("rd_r0", 0);

    // Host write and read of same register on the same edge: old value returned
    bus.host_we = 1'b1; bus.host_addr = 4'd5; bus.host_wdata = 4'd11;
    bus.busreq = 4'b0001; bus.opnd = 4'd5;
    step();
    bus.host_we = 1'b0;
    check("nobypass_data", int'(bus.data_out), m_regs[5]);
    model_write(5, 11);
    bus.busreq = 4'b0000;
    step();
    do_read("rd_r5", 5);

    // Writeback R3=8, carry=1
    writeback(3, 8, 1);
    step();
    bus.done = 1'b0;
    if (WB_EN) begin m_regs[3] = 8; m_carry = 1; end
    check("wb_carry", int'(bus.carry_flag), m_carry);
    step();
    do_read("wb_rd_r3", 3);

    // Same-edge host write and writeback to R2: host wins, carry still updates
    bus.host_we = 1'b1; bus.host_addr = 4'd2; bus.host_wdata = 4'd9;
    writeback(2, 1, 0);
    step();
    bus.host_we = 1'b0; bus.done = 1'b0;
    model_write(2, 9);
    if (WB_EN) m_carry = 0;
    check("coll_carry", int'(bus.carry_flag), m_carry);
    step();
    do_read("coll_rd_r2", 2);

    // Done edge during an operand handshake aborts it without advancing pointer
    bus.busreq = 4'b0011;
    step();
    check("abort_pre", int'(bus.next_opnd), m_ptr);
    writeback(6, 2, 1);
    step();
    bus.done = 1'b0;
    check("abort_valid", int'(bus.opnd_valid), WB_EN ? 0 : 1);
    if (WB_EN) begin m_regs[6] = 2; m_carry = 1; end
    bus.busreq = 4'b0000;
    step();
    if (!WB_EN) m_ptr = (m_ptr + 1) % 16;
    check("abort_carry", int'(bus.carry_flag), m_carry);
    do_opnd("abort_next");
    do_read("wb_rd_r6", 6);

    // Randomized host writes and reads
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(15, 0));
      d = int'($urandom_range(15, 0));
      host_write(a, d);
      a = int'($urandom_range(15, 0));
      do_read($sformatf("rnd%0d", i), a);
    end

    // Reset during READ clears outputs without a clock edge
    bus.busreq = 4'b0001; bus.opnd = 4'd3;
    step();
    check("pre_rst_valid", int'(bus.data_valid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(bus.data_valid), 0);
    check("mid_rst_data", int'(bus.data_out), 0);
    bus.busreq = 4'b0000;
    model_reset();
    step();
    rst = 1'b0;
    step();
    do_opnd("post_rst_opnd");
    do_read("post_rst_r3", 3);
    check("post_rst_carry", int'(bus.carry_flag), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
